// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: wormhole round-robin arbiter sharing one credited NoC output link.
// Define NOC_ARB_PROTOCOL_CHECK_EN to add the sticky head/tail protocol error flag o_proto_err.
module noc_port_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 32,
    parameter int  CREDITS = 8,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic [NUM_REQ-1:0]            i_req_empty,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_pop,
    output logic                          o_valid,
    output logic [WIDTH-1:0]              o_data,
    input  logic                          i_credit_return,
    output logic [CW-1:0]                 o_credit_count,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
    ,
    output logic                          o_proto_err
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      owner;
    logic [CW-1:0]      credit_cnt;
    logic [NUM_REQ-1:0] grant;
    logic               vld_p1;
    logic [WIDTH-1:0]   data_p1;

    logic               eligible;
    logic               found;
    logic               pop_vld;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      pop_idx;
    logic [NUM_REQ-1:0] pop_vec;
    logic [WIDTH-1:0]   pop_flit;
    logic               pop_tail;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
    endfunction

    // Stage p0: round-robin search from ptr, pop decision against registered credits
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && !i_req_empty[PW'((int'(ptr) + i) % NUM_REQ)]) begin
                found  = 1'b1;
                winner = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        eligible = (credit_cnt != '0);
        pop_idx  = (state == S_LOCKED) ? owner : winner;
        pop_vld  = eligible && !i_clear && !rst &&
                   ((state == S_LOCKED) ? !i_req_empty[owner] : found);
        pop_vec  = '0;
        if (pop_vld) pop_vec[pop_idx] = 1'b1;
        pop_flit = i_req_data[pop_idx];
        pop_tail = pop_flit[WIDTH-2];
    end

    // Stage p1: registered push strobe, credit accounting, packet lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            credit_cnt <= CW'(CREDITS);
            vld_p1     <= 1'b0;
            data_p1    <= '0;
        end else if (i_clear) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            credit_cnt <= CW'(CREDITS);
            vld_p1     <= 1'b0;
            data_p1    <= '0;
        end else begin
            vld_p1 <= pop_vld;
            if (pop_vld) data_p1 <= pop_flit;

            case ({pop_vld, i_credit_return})
                2'b10:   credit_cnt <= credit_cnt - CW'(1);
                2'b01:   if (credit_cnt != CW'(CREDITS)) credit_cnt <= credit_cnt + CW'(1);
                default: ;
            endcase

            if (pop_vld) begin
                if (state == S_IDLE) begin
                    // A head+tail flit never takes the lock; only the pointer moves
                    if (pop_tail) begin
                        ptr <= next_idx(pop_idx);
                    end else begin
                        state <= S_LOCKED;
                        owner <= pop_idx;
                        grant <= pop_vec;
                    end
                end else if (pop_tail) begin
                    state <= S_IDLE;
                    ptr   <= next_idx(owner);
                    grant <= '0;
                end
            end
        end
    end

`ifdef NOC_ARB_PROTOCOL_CHECK_EN
    logic proto_err;
    logic pop_head;

    assign pop_head = pop_flit[WIDTH-1];

    // A head is required exactly when the link is not locked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (i_clear) begin
            proto_err <= 1'b0;
        end else if (pop_vld && (pop_head == (state == S_LOCKED))) begin
            proto_err <= 1'b1;
        end
    end

    assign o_proto_err = proto_err;
`endif

    assign o_req_pop      = pop_vec;
    assign o_valid        = vld_p1;
    assign o_data         = data_p1;
    assign o_credit_count = credit_cnt;
    assign o_grant        = grant;
    assign o_busy         = (state == S_LOCKED);

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter: modelled requester FIFOs, queued expected flits, directed scenarios.
module tb_noc_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int DEPTH   = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          i_clear;
    logic [NUM_REQ-1:0]            i_req_empty;
    logic [NUM_REQ-1:0][WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_pop;
    logic                          o_valid;
    logic [WIDTH-1:0]              o_data;
    logic                          i_credit_return;
    logic [CW-1:0]                 o_credit_count;
    logic [NUM_REQ-1:0]            o_grant;
    logic                          o_busy;
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
    logic                          o_proto_err;
`endif

    noc_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (i_clear),
        .i_req_empty     (i_req_empty),
        .i_req_data      (i_req_data),
        .o_req_pop       (o_req_pop),
        .o_valid         (o_valid),
        .o_data          (o_data),
        .i_credit_return (i_credit_return),
        .o_credit_count  (o_credit_count),
        .o_grant         (o_grant),
        .o_busy          (o_busy)
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
        ,
        .o_proto_err     (o_proto_err)
`endif
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0]   fmem [NUM_REQ][DEPTH];
    int                 fhead [NUM_REQ];
    int                 ftail [NUM_REQ];
    logic [WIDTH-1:0]   exp_q [$];
    logic [WIDTH-1:0]   mon_exp;
    int                 checks = 0;
    int                 errors = 0;
    logic               auto_ret = 1'b0;
    logic               ret_req = 1'b0;
    logic               prev_valid = 1'b0;
    logic [NUM_REQ-1:0] pop_snap = '0;

    // Flit layout: [15] head, [14] tail, [13:8] requester, [7:0] sequence
    function automatic logic [WIDTH-1:0] mk(input logic h, input logic t, input int r, input int s);
        logic [WIDTH-1:0] f;
        f        = '0;
        f[15]    = h;
        f[14]    = t;
        f[13:8]  = 6'(r);
        f[7:0]   = 8'(s);
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load(input int r, input logic [WIDTH-1:0] f, input bit expect_now);
        fmem[r][ftail[r]] = f;
        ftail[r]++;
        if (expect_now) exp_q.push_back(f);
    endtask

    task automatic drive_fifo();
        for (int r = 0; r < NUM_REQ; r++) begin
            if (fhead[r] == ftail[r]) begin
                i_req_empty[r] = 1'b1;
                i_req_data[r]  = '0;
            end else begin
                i_req_empty[r] = 1'b0;
                i_req_data[r]  = fmem[r][fhead[r]];
            end
        end
    endtask

    // One clock cycle: drive inputs, capture the pop just before the edge, retire popped flits
    task automatic tick();
        logic cur_valid;
        i_credit_return = ret_req | (auto_ret & prev_valid);
        drive_fifo();
        #2;
        pop_snap  = o_req_pop;
        cur_valid = o_valid;
        @(posedge clk);
        for (int r = 0; r < NUM_REQ; r++)
            if (pop_snap[r] && fhead[r] != ftail[r]) fhead[r]++;
        prev_valid = cur_valid;
        ret_req    = 1'b0;
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit actual=%0h expected=none", o_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("flit", 32'(o_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        rst             = 1'b1;
        i_clear         = 1'b0;
        i_credit_return = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            fhead[r] = 0;
            ftail[r] = 0;
        end

        // Reset state, with a non-empty requester present
        load(2, mk(1'b1, 1'b1, 2, 0), 1'b0);
        drive_fifo();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pop",    32'(o_req_pop),      32'h0);
        chk("rst_valid",  32'(o_valid),        32'h0);
        chk("rst_data",   32'(o_data),         32'h0);
        chk("rst_grant",  32'(o_grant),        32'h0);
        chk("rst_busy",   32'(o_busy),         32'h0);
        chk("rst_credit", 32'(o_credit_count), 32'(CREDITS));
        fhead[2] = ftail[2];
        drive_fifo();
        rst = 1'b0;

        // Single-flit round robin: 0,1,2,3,0
        auto_ret = 1'b1;
        load(0, mk(1'b1, 1'b1, 0, 0), 1'b1);
        load(1, mk(1'b1, 1'b1, 1, 0), 1'b1);
        load(2, mk(1'b1, 1'b1, 2, 0), 1'b1);
        load(3, mk(1'b1, 1'b1, 3, 0), 1'b1);
        load(0, mk(1'b1, 1'b1, 0, 1), 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_pop",   32'(pop_snap), 32'(1 << (k % 4)));
            chk("rr_grant", 32'(o_grant),  32'h0);
            chk("rr_valid", 32'(o_valid),  32'h1);
        end
        repeat (3) tick();
        chk("rr_credit_back", 32'(o_credit_count), 32'(CREDITS));

        // Wormhole lock: requester 1 three-flit packet, then requester 2
        load(1, mk(1'b1, 1'b0, 1, 1), 1'b1);
        load(1, mk(1'b0, 1'b0, 1, 2), 1'b1);
        load(1, mk(1'b0, 1'b1, 1, 3), 1'b1);
        load(2, mk(1'b1, 1'b1, 2, 1), 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wh_pop",   32'(pop_snap), (k < 3) ? 32'h2 : 32'h4);
            chk("wh_grant", 32'(o_grant),  (k < 2) ? 32'h2 : 32'h0);
            chk("wh_busy",  32'(o_busy),   (k < 2) ? 32'h1 : 32'h0);
        end
        repeat (3) tick();
        chk("wh_credit_back", 32'(o_credit_count), 32'(CREDITS));

        // Credit exhaustion, return timing, pop+return at count 1, return at full
        auto_ret = 1'b0;
        for (int s = 0; s < 6; s++) load(3, mk(1'b1, 1'b1, 3, 10 + s), 1'b1);
        for (int k = 0; k < CREDITS; k++) begin
            tick();
            chk("cr_pop", 32'(pop_snap), 32'h8);
        end
        chk("cr_zero", 32'(o_credit_count), 32'h0);
        tick();
        chk("cr_stall_pop", 32'(pop_snap), 32'h0);
        ret_req = 1'b1;
        tick();
        chk("cr_ret_same_cycle_pop", 32'(pop_snap),       32'h0);
        chk("cr_ret_count",          32'(o_credit_count), 32'h1);
        tick();
        chk("cr_after_ret_pop", 32'(pop_snap),       32'h8);
        chk("cr_after_ret_cnt", 32'(o_credit_count), 32'h0);
        tick();
        chk("cr_second_stall_pop", 32'(pop_snap), 32'h0);
        ret_req = 1'b1;
        tick();
        chk("cr_ret_to_one", 32'(o_credit_count), 32'h1);
        ret_req = 1'b1;
        tick();
        chk("cr_pop_ret_pop",   32'(pop_snap),       32'h8);
        chk("cr_pop_ret_count", 32'(o_credit_count), 32'h1);
        repeat (3) begin
            ret_req = 1'b1;
            tick();
        end
        chk("cr_refill", 32'(o_credit_count), 32'(CREDITS));
        ret_req = 1'b1;
        tick();
        chk("cr_ret_at_full", 32'(o_credit_count), 32'(CREDITS));

        // Owner starvation: requester 0 stalls mid-packet, requester 3 waits
        auto_ret = 1'b1;
        load(0, mk(1'b1, 1'b0, 0, 20), 1'b1);
        load(3, mk(1'b1, 1'b1, 3, 20), 1'b0);
        tick();
        chk("st_head_pop", 32'(pop_snap), 32'h1);
        chk("st_grant",    32'(o_grant),  32'h1);
        chk("st_busy",     32'(o_busy),   32'h1);
        repeat (4) begin
            tick();
            chk("st_starve_pop",  32'(pop_snap), 32'h0);
            chk("st_starve_busy", 32'(o_busy),   32'h1);
        end
        load(0, mk(1'b0, 1'b1, 0, 21), 1'b1);
        exp_q.push_back(mk(1'b1, 1'b1, 3, 20));
        tick();
        chk("st_tail_pop",  32'(pop_snap), 32'h1);
        chk("st_tail_busy", 32'(o_busy),   32'h0);
        tick();
        chk("st_next_pop",   32'(pop_snap), 32'h8);
        chk("st_next_grant", 32'(o_grant),  32'h0);
        repeat (2) tick();
        chk("st_credit_back", 32'(o_credit_count), 32'(CREDITS));

        // Clear in LOCKED, then a headless flit popped from IDLE
        auto_ret = 1'b0;
        load(1, mk(1'b1, 1'b0, 1, 30), 1'b1);
        load(1, mk(1'b0, 1'b0, 1, 31), 1'b1);
        tick();
        chk("cl_head_pop", 32'(pop_snap), 32'h2);
        chk("cl_grant",    32'(o_grant),  32'h2);
        tick();
        chk("cl_body_pop", 32'(pop_snap), 32'h2);
        chk("cl_busy",     32'(o_busy),   32'h1);
        load(1, mk(1'b0, 1'b0, 1, 32), 1'b1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("cl_pop_blocked", 32'(pop_snap),       32'h0);
        chk("cl_busy_after",  32'(o_busy),         32'h0);
        chk("cl_grant_after", 32'(o_grant),        32'h0);
        chk("cl_credit",      32'(o_credit_count), 32'(CREDITS));
        chk("cl_valid",       32'(o_valid),        32'h0);
        chk("cl_data",        32'(o_data),         32'h0);
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
        chk("pe_after_clear", 32'(o_proto_err), 32'h0);
`endif
        tick();
        chk("cl_idle_pop", 32'(pop_snap), 32'h2);
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
        chk("pe_set", 32'(o_proto_err), 32'h1);
`endif
        tick();
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
        chk("pe_held", 32'(o_proto_err), 32'h1);
`endif
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("cl2_busy", 32'(o_busy), 32'h0);
`ifdef NOC_ARB_PROTOCOL_CHECK_EN
        chk("pe_cleared", 32'(o_proto_err), 32'h0);
`endif
        tick();
        chk("exp_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
